// File: rtl/lsu_axi_wr_io_sink.sv
// lsu_axi_wr_io_sink
// AXI4 write-channel slave that terminates the LSU write port. Accepted
// write beats that hit the decode window are reduced to one 32-bit lane
// (OUT_W bits kept) and buffered in a DEPTH-entry FIFO. The FIFO drains
// over a valid/ready stream toward the pads. Every transaction gets a
// B response carrying the captured ID.
//
// Optional feature macro: LSU_AXI_WR_IO_SINK_DECERR_EN
//   defined   : address decode active; a miss returns DECERR and its data
//               is discarded.
//   undefined : every address is treated as a hit (always OKAY).
module lsu_axi_wr_io_sink #(
  parameter int          ID_W      = 3,
  parameter int          OUT_W     = 28,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'hd058_0000,
  parameter logic [31:0] ADDR_MASK = 32'hffff_f000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ID_W-1:0]            awid,
  input  logic [31:0]                awaddr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [63:0]                wdata,
  input  logic [7:0]                 wstrb,
  input  logic                       wlast,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [ID_W-1:0]            bid,
  output logic [1:0]                 bresp,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Select the 32-bit lane named by the strobes: low lane when any low
  // byte is enabled, otherwise the high lane.
  function automatic logic [OUT_W-1:0] lane_sel(input logic [63:0] d,
                                                input logic [7:0]  s);
    logic [OUT_W-1:0] r;
    if (|s[3:0]) begin
      r = d[OUT_W-1:0];
    end else begin
      r = d[32+OUT_W-1:32];
    end
    return r;
  endfunction

  state_t            state_r;
  logic [ID_W-1:0]   id_r;
  logic              hit_r;
  logic              bvalid_r;
  logic [ID_W-1:0]   bid_r;
  logic [1:0]        bresp_r;

  logic [OUT_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [OUT_W-1:0]  out_data_r;
  logic              out_valid_r;

  logic              hit_s;
  logic              full_s;
  logic              awready_s;
  logic              wready_s;
  logic              w_acc_s;
  logic              push_s;
  logic              pop_s;
  logic [OUT_W-1:0]  push_word_s;
  logic [LW-1:0]     level_after_pop_s;
  logic [LW-1:0]     level_nxt_s;
  logic [AW-1:0]     rd_nxt_s;
  logic [OUT_W-1:0]  head_nxt_s;
  logic              unused_s;

  // Address decode for the window (or a forced hit when decode is disabled).
`ifdef LSU_AXI_WR_IO_SINK_DECERR_EN
  assign hit_s = ((awaddr & ADDR_MASK) == BASE_ADDR);
`else
  assign hit_s = 1'b1;
`endif

  // Handshake decode, FIFO push/pop and next-head computation.
  always_comb begin
    unused_s    = ^{awaddr, wdata, wstrb};
    full_s      = (level_r == LW'(DEPTH));
    awready_s   = (state_r == ST_IDLE);
    if (state_r == ST_DATA) begin
      if (hit_r) begin
        wready_s = ~full_s;
      end else begin
        wready_s = 1'b1;
      end
    end else begin
      wready_s = 1'b0;
    end
    w_acc_s     = wvalid & wready_s;
    push_s      = w_acc_s & hit_r & (wstrb != 8'h00);
    pop_s       = out_valid_r & out_ready;
    push_word_s = lane_sel(wdata, wstrb);
    level_after_pop_s = level_r - {{(LW-1){1'b0}}, pop_s};
    level_nxt_s = level_after_pop_s + {{(LW-1){1'b0}}, push_s};
    rd_nxt_s    = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
    if (level_nxt_s == {LW{1'b0}}) begin
      head_nxt_s = out_data_r;
    end else if (level_after_pop_s == {LW{1'b0}}) begin
      head_nxt_s = push_word_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Transaction FSM: AW capture, W beat consumption, registered B response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r  <= ST_IDLE;
      id_r     <= {ID_W{1'b0}};
      hit_r    <= 1'b0;
      bvalid_r <= 1'b0;
      bid_r    <= {ID_W{1'b0}};
      bresp_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (awvalid) begin
            id_r    <= awid;
            hit_r   <= hit_s;
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_acc_s && wlast) begin
            state_r  <= ST_RESP;
            bvalid_r <= 1'b1;
            bid_r    <= id_r;
            bresp_r  <= hit_r ? 2'b00 : 2'b11;
          end
        end
        ST_RESP: begin
          if (bready) begin
            state_r  <= ST_IDLE;
            bvalid_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          bvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage, pointers, occupancy and registered head word.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {OUT_W{1'b0}};
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      out_data_r  <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      rd_ptr_r    <= rd_nxt_s;
      level_r     <= level_nxt_s;
      out_data_r  <= head_nxt_s;
      out_valid_r <= (level_nxt_s != {LW{1'b0}});
    end
  end

  assign awready   = awready_s;
  assign wready    = wready_s;
  assign bvalid    = bvalid_r;
  assign bid       = bid_r;
  assign bresp     = bresp_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign level     = level_r;

endmodule
